// File: rtl/axi_imem_read_slave.sv
// AXI4 read-only slave over an internal preloadable word memory.
// One outstanding burst; beats are produced from a registered memory read.
module axi_imem_read_slave #(
    parameter int DATA_LENGTH = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int ID_WIDTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic [ID_WIDTH-1:0]            ARID,
    input  logic [31:0]                    ARADDR,
    input  logic [3:0]                     ARLEN,
    input  logic [2:0]                     ARSIZE,
    input  logic [1:0]                     ARBURST,
    input  logic                           ARVALID,
    output logic                           ARREADY,

    output logic [ID_WIDTH-1:0]            RID,
    output logic [DATA_LENGTH-1:0]         RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RLAST,
    output logic                           RVALID,
    input  logic                           RREADY,

    input  logic                           load_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [DATA_LENGTH-1:0]         load_data
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [DATA_LENGTH-1:0] mem [DEPTH_WORDS];

    logic [29:0]            addr_reg;
    logic [3:0]             len_reg;
    logic [1:0]             burst_reg;
    logic                   err_reg;
    logic [3:0]             cnt_reg;
    logic [3:0]             cnt_next;
    logic [ID_WIDTH-1:0]    rid_reg;
    logic [DATA_LENGTH-1:0] rdata_reg;
    logic [1:0]             rresp_reg;
    logic                   rlast_reg;
    logic                   rvalid_reg;
    logic                   arready_reg;

    logic                   ar_hs;
    logic                   ar_err;
    logic                   wrap_len_ok;
    logic                   load_beat;
    logic                   clear_beat;
    logic [29:0]            beat_addr;
    logic                   beat_err;
    logic                   beat_last;
    logic                   beat_oob;
    logic                   beat_bad;
    logic [AW-1:0]          beat_idx;
    logic [29:0]            addr_inc;
    logic [29:0]            wrap_mask;
    logic [29:0]            next_addr;
    logic                   unused_addr_lsb;

    // Byte offset within a word carries no meaning for a word-only memory.
    assign unused_addr_lsb = ^ARADDR[1:0];

    assign ar_hs = (state_reg == IDLE) && arready_reg && ARVALID;

    always_comb begin
        wrap_len_ok = 1'b0;
        case (ARLEN)
            4'd1, 4'd3, 4'd7, 4'd15: wrap_len_ok = 1'b1;
            default:                 wrap_len_ok = 1'b0;
        endcase
    end

    assign ar_err = (ARSIZE != 3'b010) || (ARBURST == 2'b11)
                  || ((ARBURST == BURST_WRAP) && !wrap_len_ok);

    // Wrap lengths are 2^n-1, so the length itself is the in-block offset mask.
    assign addr_inc  = addr_reg + 30'd1;
    assign wrap_mask = {26'd0, len_reg};

    always_comb begin
        next_addr = addr_inc;
        case (burst_reg)
            BURST_FIXED: next_addr = addr_reg;
            BURST_WRAP:  next_addr = (addr_reg & ~wrap_mask) | (addr_inc & wrap_mask);
            default:     next_addr = addr_inc;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        load_beat  = 1'b0;
        clear_beat = 1'b0;
        beat_addr  = addr_reg;
        beat_err   = err_reg;
        beat_last  = 1'b0;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (ar_hs) begin
                    state_next = SEND;
                    load_beat  = 1'b1;
                    beat_addr  = ARADDR[31:2];
                    beat_err   = ar_err;
                    cnt_next   = 4'd0;
                    beat_last  = (ARLEN == 4'd0);
                end
            end
            SEND: begin
                if (rvalid_reg && RREADY) begin
                    if (rlast_reg) begin
                        state_next = IDLE;
                        clear_beat = 1'b1;
                    end else begin
                        load_beat = 1'b1;
                        beat_addr = next_addr;
                        cnt_next  = cnt_reg + 4'd1;
                        beat_last = (cnt_next == len_reg);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign beat_oob = (beat_addr >= 30'(DEPTH_WORDS));
    assign beat_bad = beat_err || beat_oob;
    assign beat_idx = beat_addr[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rid_reg     <= '0;
            cnt_reg     <= 4'd0;
            addr_reg    <= 30'd0;
            len_reg     <= 4'd0;
            burst_reg   <= 2'b00;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            arready_reg <= (state_next == IDLE);
            rvalid_reg  <= (state_next == SEND);
            if (ar_hs) begin
                rid_reg   <= ARID;
                len_reg   <= ARLEN;
                burst_reg <= ARBURST;
                err_reg   <= ar_err;
            end
            if (load_beat) begin
                addr_reg  <= beat_addr;
                cnt_reg   <= cnt_next;
                rlast_reg <= beat_last;
                rresp_reg <= beat_bad ? RESP_SLVERR : RESP_OKAY;
            end else if (clear_beat) begin
                rlast_reg <= 1'b0;
            end
        end
    end

    // Registered read: a same-edge preload to this word is seen only next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (load_beat) begin
            rdata_reg <= beat_bad ? '0 : mem[beat_idx];
        end
    end

    // Preload port is independent of reset so images survive a bus reset.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end
    end

    assign ARREADY = arready_reg;
    assign RVALID  = rvalid_reg;
    assign RLAST   = rlast_reg;
    assign RRESP   = rresp_reg;
    assign RDATA   = rdata_reg;
    assign RID     = rid_reg;

endmodule

// File: tb/tb_axi_imem_read_slave.sv
// Directed bench for axi_imem_read_slave: bursts, wrap, backpressure,
// error responses, mid-burst reset and preload collision.
module tb_axi_imem_read_slave;

    logic        clk;
    logic        rst;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        load_we;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_data [16];
    logic [1:0]  exp_resp [16];

    axi_imem_read_slave #(
        .DATA_LENGTH(32),
        .DEPTH_WORDS(1024),
        .ID_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one AR beat; optionally collide a preload write with the handshake edge.
    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input bit coll, input logic [9:0] waddr, input logic [31:0] wdata);
        @(negedge clk);
        chk("ar_ready_before", ARREADY, 1'b1);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARVALID = 1'b1;
        if (coll) begin
            load_we = 1'b1; load_addr = waddr; load_data = wdata;
        end
        @(posedge clk);
        #1;
        ARVALID = 1'b0;
        load_we = 1'b0;
    endtask

    // Receive n beats; bp selects RREADY pattern 1,0,0,1,0,0,...
    task automatic recv(input string name, input int n, input logic [3:0] id, input bit bp);
        int k = 0;
        int c = 0;
        while (k < n && c < 200) begin
            @(negedge clk);
            chk({name, "_rvalid"}, RVALID, 1'b1);
            chk({name, "_rdata"},  RDATA,  exp_data[k]);
            chk({name, "_rresp"},  RRESP,  exp_resp[k]);
            chk({name, "_rlast"},  RLAST,  (k == n - 1));
            chk({name, "_rid"},    RID,    id);
            chk({name, "_arready_busy"}, ARREADY, 1'b0);
            RREADY = bp ? (c % 3 == 0) : 1'b1;
            if (RREADY) k++;
            c++;
        end
        @(negedge clk);
        RREADY = 1'b0;
        chk({name, "_done_rvalid"},  RVALID,  1'b0);
        chk({name, "_done_rlast"},   RLAST,   1'b0);
        chk({name, "_done_arready"}, ARREADY, 1'b1);
        $display("burst %s: %0d beats id=%0d checked", name, n, id);
    endtask

    initial begin
        rst = 1'b1;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010; ARBURST = 2'b01;
        ARVALID = 1'b0; RREADY = 1'b0;
        load_we = 1'b0; load_addr = '0; load_data = '0;

        // Preload while in reset: load port must still write.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            load_we = 1'b1; load_addr = 10'(i); load_data = 32'h1000 + 32'(i);
        end
        @(negedge clk); load_addr = 10'd1022; load_data = 32'h0000A3FE;
        @(negedge clk); load_addr = 10'd1023; load_data = 32'h0000A3FF;
        @(negedge clk);
        load_we = 1'b0;
        chk("rst_arready", ARREADY, 1'b0);
        chk("rst_rvalid",  RVALID,  1'b0);
        chk("rst_rlast",   RLAST,   1'b0);
        chk("rst_rdata",   RDATA,   32'h0);
        chk("rst_rresp",   RRESP,   2'b00);
        chk("rst_rid",     RID,     4'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", ARREADY, 1'b1);
        $display("reset released, ARREADY checked");

        // INCR 0x10 len 3 -> words 4..7
        for (int i = 0; i < 4; i++) begin
            exp_data[i] = 32'h1004 + 32'(i); exp_resp[i] = 2'b00;
        end
        do_ar(4'd5, 32'h10, 4'd3, 3'b010, 2'b01, 1'b0, 10'd0, 32'd0);
        recv("incr", 4, 4'd5, 1'b0);

        // WRAP 0x18 len 3 -> words 6,7,4,5
        exp_data[0] = 32'h1006; exp_data[1] = 32'h1007;
        exp_data[2] = 32'h1004; exp_data[3] = 32'h1005;
        do_ar(4'd2, 32'h18, 4'd3, 3'b010, 2'b10, 1'b0, 10'd0, 32'd0);
        recv("wrap", 4, 4'd2, 1'b0);

        // Backpressure, INCR 0x22 (low bits ignored) -> words 8..11
        for (int i = 0; i < 4; i++) begin
            exp_data[i] = 32'h1008 + 32'(i); exp_resp[i] = 2'b00;
        end
        do_ar(4'd7, 32'h22, 4'd3, 3'b010, 2'b01, 1'b0, 10'd0, 32'd0);
        recv("bp", 4, 4'd7, 1'b1);

        // FIXED 0x8 len 2 -> word 2 three times
        for (int i = 0; i < 3; i++) exp_data[i] = 32'h1002;
        do_ar(4'd1, 32'h8, 4'd2, 3'b010, 2'b00, 1'b0, 10'd0, 32'd0);
        recv("fixed", 3, 4'd1, 1'b0);

        // Single beat
        exp_data[0] = 32'h100F;
        do_ar(4'd9, 32'h3C, 4'd0, 3'b010, 2'b01, 1'b0, 10'd0, 32'd0);
        recv("single", 1, 4'd9, 1'b0);

        // INCR crossing the end of memory: words 1022,1023 ok, 1024,1025 SLVERR
        exp_data[0] = 32'hA3FE; exp_resp[0] = 2'b00;
        exp_data[1] = 32'hA3FF; exp_resp[1] = 2'b00;
        exp_data[2] = 32'h0;    exp_resp[2] = 2'b10;
        exp_data[3] = 32'h0;    exp_resp[3] = 2'b10;
        do_ar(4'd3, 32'hFF8, 4'd3, 3'b010, 2'b01, 1'b0, 10'd0, 32'd0);
        recv("oob", 4, 4'd3, 1'b0);

        // Bad ARSIZE -> 2 SLVERR beats
        for (int i = 0; i < 3; i++) begin
            exp_data[i] = 32'h0; exp_resp[i] = 2'b10;
        end
        do_ar(4'd4, 32'h0, 4'd1, 3'b001, 2'b01, 1'b0, 10'd0, 32'd0);
        recv("badsize", 2, 4'd4, 1'b0);

        // WRAP with illegal length 2 -> 3 SLVERR beats
        do_ar(4'd6, 32'h4, 4'd2, 3'b010, 2'b10, 1'b0, 10'd0, 32'd0);
        recv("badwrap", 3, 4'd6, 1'b0);

        // Mid-burst reset during beat 2 of 8
        do_ar(4'd8, 32'h0, 4'd7, 3'b010, 2'b01, 1'b0, 10'd0, 32'd0);
        @(negedge clk);
        chk("mrst_beat1", RDATA, 32'h1000);
        RREADY = 1'b1;
        @(negedge clk);
        chk("mrst_beat2", RDATA, 32'h1001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        RREADY = 1'b0;
        chk("mrst_rvalid",  RVALID,  1'b0);
        chk("mrst_rlast",   RLAST,   1'b0);
        chk("mrst_arready", ARREADY, 1'b0);
        @(negedge clk);
        chk("mrst_arready_back", ARREADY, 1'b1);
        chk("mrst_rvalid_idle",  RVALID,  1'b0);
        $display("mid-burst reset checked");
        exp_data[0] = 32'h1001; exp_resp[0] = 2'b00;
        exp_data[1] = 32'h1002; exp_resp[1] = 2'b00;
        do_ar(4'd10, 32'h4, 4'd1, 3'b010, 2'b01, 1'b0, 10'd0, 32'd0);
        recv("after_rst", 2, 4'd10, 1'b0);

        // Collision: preload word 5 on the edge its beat is read -> old value
        exp_data[0] = 32'h1005; exp_resp[0] = 2'b00;
        do_ar(4'd3, 32'h14, 4'd0, 3'b010, 2'b01, 1'b1, 10'd5, 32'hDEAD);
        recv("coll_old", 1, 4'd3, 1'b0);
        exp_data[0] = 32'hDEAD;
        do_ar(4'd3, 32'h14, 4'd0, 3'b010, 2'b01, 1'b0, 10'd0, 32'd0);
        recv("coll_new", 1, 4'd3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
